s_fold_misr: RTL and testbench
==============================

Name: s_fold_misr

Overview:
- Downstream compaction stage for the 16→8-bit XOR fold stage (aa = a[7:0]^a[15:8], bb = b[7:0]^b[15:8]).
- Consumes a handshaked stream of folded aa/bb byte pairs.
- Compresses each lane into an 8-bit MISR signature over a fixed sample count.
- Presents both signatures on a valid/ready output port; used as the on-chip response compactor for fold-datapath checks.

Parameters:
- NSAMP, 16, number of accepted aa/bb pairs per signature; legal range 1..65535.
- POLY, 8'h1D, MISR feedback polynomial, low 8 bits; x^8 implied.
- SEED, 8'hFF, MISR initial value loaded on start.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a signature run; honoured in IDLE only
- in_valid  input  1  aa/bb pair valid
- in_ready  output  1  block accepts pair this cycle
- aa  input  8  folded a lane from upstream XOR stage
- bb  input  8  folded b lane from upstream XOR stage
- sig_valid  output  1  signatures valid
- sig_ready  input  1  consumer accepts signatures
- sig_aa  output  8  MISR signature, aa lane
- sig_bb  output  8  MISR signature, bb lane
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All state is in flops on clk posedge, cleared asynchronously by rst_n.
- Reset values: state=IDLE, in_ready=0, sig_valid=0, sig_aa=0, sig_bb=0, busy=0, sample counter=0.
- in_ready and sig_valid are registered state decodes, not combinational through in_valid or sig_ready.
- Accept condition: in_valid & in_ready. Output transfer: sig_valid & sig_ready.
- MISR update, per lane, on accept: next = ({sig[6:0],1'b0} ^ (sig[7] ? POLY : 0)) ^ din, where din is aa or bb. Both lanes update in the same cycle.
- Counter width: $clog2(NSAMP+1). Counter increments on accept and is never exposed.
- FSM IDLE:
  - in_ready=0; sig_valid=0.
  - start=1 → sig_aa=sig_bb=SEED, counter=0, next state RUN.
  - in_valid is ignored.
- FSM RUN:
  - in_ready=1.
  - Accept with counter==NSAMP-1 → final MISR update, next state DONE. The next cycle has sig_valid=1 and in_ready=0.
  - No accept → MISRs and counter hold.
  - start is ignored.
- FSM DONE:
  - sig_valid=1, in_ready=0; sig_aa and sig_bb hold stable while sig_ready=0.
  - Output transfer → next state IDLE; sig_aa and sig_bb retain their last values; sig_valid drops the next cycle.
  - start is ignored, including start coincident with the transfer cycle.
- Latency:
  - First pair is accepted the cycle after start at the earliest.
  - sig_valid rises 1 cycle after the NSAMP-th accept.
  - Minimum run with continuous in_valid: 1 + NSAMP + 1 cycles from start to sig_valid.
- Boundary cases:
  - NSAMP=1: the single accept goes directly to DONE.
  - A stall of any length mid-run does not corrupt the signature.
  - rst_n asserted in any state → immediate return to reset values; the partial signature is discarded.
  - in_valid held high across RUN→DONE: no extra pair is consumed.

Optional Feature:
- Macro: S_FOLD_MISR_PAR_EN.
- Defined:
  - Adds output port sig_par, 1 bit, = ^{sig_aa, sig_bb}.
  - Registered: updated on the same edges as the signatures; reset value 0.
  - Lets the downstream consumer check the 16-bit signature transfer.
- Undefined:
  - Port absent; no extra flops.
  - All other behaviour is identical.

Test Plan:
- NSAMP=1, start, then aa=8'h00, bb=8'h5A with in_valid=1 → sig_valid one cycle after accept; sig_aa=8'hE3, sig_bb=8'hB9.
- NSAMP=2, aa=bb=8'h00 for two accepts → sig_aa=sig_bb=8'hDB; exactly 2 accepts occur although in_valid stays high 5 cycles.
- NSAMP=2, in_valid toggling 1,0,0,1 with aa=8'h00 → sig_aa=8'hDB (stalls ignored); start pulsed during RUN has no effect.
- In DONE, hold sig_ready=0 for 5 cycles → sig_valid=1 and sig_aa/sig_bb constant; sig_ready=1 → IDLE next cycle, in_ready stays 0.
- rst_n low for 1 cycle after 1 of 2 accepts → all outputs 0 immediately; a new start and 2 zero pairs yield 8'hDB again.
- With S_FOLD_MISR_PAR_EN defined, NSAMP=1 test 1 → sig_par = ^(8'hE3 ^ 8'hB9) = ^8'h5A = 0; reset value 0.

Source files
------------

// File: rtl/s_fold_misr.sv
// Dual-lane 8-bit MISR compactor for folded aa/bb byte pairs, one signature pair per NSAMP accepts.
// Optional macro S_FOLD_MISR_PAR_EN adds a registered parity bit (sig_par) over both signatures.
module s_fold_misr #(
  parameter int unsigned NSAMP = 16,
  parameter logic [7:0]  POLY  = 8'h1D,
  parameter logic [7:0]  SEED  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] aa,
  input  logic [7:0] bb,
  output logic       sig_valid,
  input  logic       sig_ready,
  output logic [7:0] sig_aa,
  output logic [7:0] sig_bb,
  output logic       busy
`ifdef S_FOLD_MISR_PAR_EN
  ,
  output logic       sig_par
`endif
);

  localparam int unsigned CW = $clog2(NSAMP + 1);
  localparam logic [CW-1:0] LAST = CW'(NSAMP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    saa_q, saa_d;
  logic [7:0]    sbb_q, sbb_d;
  logic          in_ready_q, in_ready_d;
  logic          sig_valid_q, sig_valid_d;
  logic          busy_q, busy_d;

  // Galois-style shift with x^8 implied, then fold in the new byte.
  function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic [7:0] din);
    misr_step = {sig[6:0], 1'b0} ^ (sig[7] ? POLY : 8'h00) ^ din;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    saa_d       = saa_q;
    sbb_d       = sbb_q;
    in_ready_d  = in_ready_q;
    sig_valid_d = sig_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          saa_d      = SEED;
          sbb_d      = SEED;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (in_valid && in_ready_q) begin
          saa_d = misr_step(saa_q, aa);
          sbb_d = misr_step(sbb_q, bb);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            in_ready_d  = 1'b0;
            sig_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        // Signatures are left in place after the transfer; only the flags drop.
        if (sig_valid_q && sig_ready) begin
          sig_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        sig_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      saa_q       <= 8'h00;
      sbb_q       <= 8'h00;
      in_ready_q  <= 1'b0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      saa_q       <= saa_d;
      sbb_q       <= sbb_d;
      in_ready_q  <= in_ready_d;
      sig_valid_q <= sig_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign sig_valid = sig_valid_q;
  assign sig_aa    = saa_q;
  assign sig_bb    = sbb_q;
  assign busy      = busy_q;

`ifdef S_FOLD_MISR_PAR_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^{saa_d, sbb_d};
    end
  end

  assign sig_par = par_q;
`endif

endmodule

// File: tb/tb_s_fold_misr.sv
// Scoreboard bench for s_fold_misr: three instances (NSAMP = 1, 2, 16) share one clock and reset.
module tb_s_fold_misr;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start     [NI];
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] aa        [NI];
  logic [7:0] bb        [NI];
  logic       sig_valid [NI];
  logic       sig_ready [NI];
  logic [7:0] sig_aa    [NI];
  logic [7:0] sig_bb    [NI];
  logic       busy      [NI];
`ifdef S_FOLD_MISR_PAR_EN
  logic       sig_par   [NI];
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [NI][$];   // {parity, sig_aa, sig_bb}
  int acc_cnt [NI];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] sig, input logic [7:0] din);
    mstep = {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ din;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NS = (g == 0) ? 1 : (g == 1) ? 2 : 16;

    s_fold_misr #(.NSAMP(NS), .POLY(8'h1D), .SEED(8'hFF)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .aa        (aa[g]),
      .bb        (bb[g]),
      .sig_valid (sig_valid[g]),
      .sig_ready (sig_ready[g]),
      .sig_aa    (sig_aa[g]),
      .sig_bb    (sig_bb[g]),
      .busy      (busy[g])
`ifdef S_FOLD_MISR_PAR_EN
      ,
      .sig_par   (sig_par[g])
`endif
    );

    initial acc_cnt[g] = 0;

    always @(negedge clk) begin : mon
      logic [16:0] e;
      if (rst_n && in_valid[g] && in_ready[g]) acc_cnt[g]++;
      if (rst_n && sig_valid[g] && sig_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          chk("sb_unexpected_sig", 32'(exp_q[g].size()), 32'd1);
        end else begin
          e = exp_q[g].pop_front();
          chk("sb_sig_aa", 32'(sig_aa[g]), 32'(e[15:8]));
          chk("sb_sig_bb", 32'(sig_bb[g]), 32'(e[7:0]));
`ifdef S_FOLD_MISR_PAR_EN
          chk("sb_sig_par", 32'(sig_par[g]), 32'(e[16]));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int g);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  // Drives one signature run and pushes the model result when the last pair is accepted.
  task automatic run(input int g, input int n, input bit stall, input bit zero);
    logic [7:0] ma = 8'hFF;
    logic [7:0] mb = 8'hFF;
    int got = 0;
    int budget = 0;
    do_start(g);
    while (got < n && budget < 2000) begin
      in_valid[g] = !stall || ($urandom_range(0, 3) != 0);
      aa[g] = zero ? 8'h00 : 8'($urandom);
      bb[g] = zero ? 8'h00 : 8'($urandom);
      @(negedge clk);
      if (in_valid[g] && in_ready[g]) begin
        ma = mstep(ma, aa[g]);
        mb = mstep(mb, bb[g]);
        got++;
        if (got == n) exp_q[g].push_back({^{ma, mb}, ma, mb});
      end
      tick();
      budget++;
    end
    chk("run_accepts", 32'(got), 32'(n));
  endtask

  task automatic drain(input int g, input bit rnd_ready);
    int budget = 0;
    while (exp_q[g].size() != 0 && budget < 200) begin
      sig_ready[g] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget++;
    end
    chk("drain_left", 32'(exp_q[g].size()), 32'd0);
    sig_ready[g] = 1'b0;
    in_valid[g]  = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int a0;
    logic [7:0] sa, sb;
    logic [7:0] ma, mb;
    logic [3:0] pat;

    for (int i = 0; i < NI; i++) begin
      start[i] = 0; in_valid[i] = 0; aa[i] = 0; bb[i] = 0; sig_ready[i] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    for (int i = 0; i < NI; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd0);
      chk("rst_sig_valid", 32'(sig_valid[i]), 32'd0);
      chk("rst_sig_aa", 32'(sig_aa[i]), 32'd0);
      chk("rst_sig_bb", 32'(sig_bb[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
`ifdef S_FOLD_MISR_PAR_EN
      chk("rst_sig_par", 32'(sig_par[i]), 32'd0);
`endif
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // NSAMP=1: single accept goes straight to DONE
    do_start(0);
    in_valid[0] = 1'b1; aa[0] = 8'h00; bb[0] = 8'h5A;
    @(negedge clk);
    chk("t1_in_ready", 32'(in_ready[0]), 32'd1);
    chk("t1_valid_early", 32'(sig_valid[0]), 32'd0);
    chk("t1_busy_run", 32'(busy[0]), 32'd1);
    tick();
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_sig_valid", 32'(sig_valid[0]), 32'd1);
    chk("t1_in_ready_done", 32'(in_ready[0]), 32'd0);
    chk("t1_sig_aa", 32'(sig_aa[0]), 32'hE3);
    chk("t1_sig_bb", 32'(sig_bb[0]), 32'hB9);
`ifdef S_FOLD_MISR_PAR_EN
    chk("t1_sig_par", 32'(sig_par[0]), 32'd0);
`endif
    exp_q[0].push_back({1'b0, 8'hE3, 8'hB9});
    tick();
    sig_ready[0] = 1'b1;
    tick();
    sig_ready[0] = 1'b0;
    @(negedge clk);
    chk("t1_valid_drop", 32'(sig_valid[0]), 32'd0);
    chk("t1_busy_idle", 32'(busy[0]), 32'd0);
    chk("t1_sig_aa_kept", 32'(sig_aa[0]), 32'hE3);
    tick();

    // NSAMP=2: in_valid high for 5 cycles, only 2 pairs consumed; then DONE hold
    a0 = acc_cnt[1];
    do_start(1);
    in_valid[1] = 1'b1; aa[1] = 8'h00; bb[1] = 8'h00;
    repeat (5) tick();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_accepts", 32'(acc_cnt[1] - a0), 32'd2);
    chk("t2_sig_valid", 32'(sig_valid[1]), 32'd1);
    chk("t2_sig_aa", 32'(sig_aa[1]), 32'hDB);
    chk("t2_sig_bb", 32'(sig_bb[1]), 32'hDB);
    sa = sig_aa[1]; sb = sig_bb[1];
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t2_hold_valid", 32'(sig_valid[1]), 32'd1);
      chk("t2_hold_aa", 32'(sig_aa[1]), 32'(sa));
      chk("t2_hold_bb", 32'(sig_bb[1]), 32'(sb));
      chk("t2_hold_in_ready", 32'(in_ready[1]), 32'd0);
    end
    exp_q[1].push_back({1'b0, 8'hDB, 8'hDB});
    tick();
    sig_ready[1] = 1'b1;
    start[1] = 1'b1;
    tick();
    sig_ready[1] = 1'b0;
    start[1] = 1'b0;
    @(negedge clk);
    chk("t2_idle_busy", 32'(busy[1]), 32'd0);
    chk("t2_idle_valid", 32'(sig_valid[1]), 32'd0);
    chk("t2_idle_in_ready", 32'(in_ready[1]), 32'd0);
    chk("t2_idle_sig_aa", 32'(sig_aa[1]), 32'hDB);
    tick();
    @(negedge clk);
    chk("t2_start_ignored", 32'(busy[1]), 32'd0);
    chk("t2_in_ready_stays0", 32'(in_ready[1]), 32'd0);
    tick();

    // NSAMP=2: stalls and a start pulse mid-run
    pat = 4'b1001;
    ma = 8'hFF; mb = 8'hFF;
    sig_ready[1] = 1'b1;
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      in_valid[1] = pat[3-i];
      aa[1] = 8'h00;
      bb[1] = 8'($urandom);
      start[1] = (i == 1);
      @(negedge clk);
      if (in_valid[1] && in_ready[1]) begin
        ma = mstep(ma, aa[1]);
        mb = mstep(mb, bb[1]);
      end
      tick();
    end
    start[1] = 1'b0;
    in_valid[1] = 1'b0;
    exp_q[1].push_back({^{ma, mb}, ma, mb});
    @(negedge clk);
    chk("t3_sig_valid", 32'(sig_valid[1]), 32'd1);
    chk("t3_sig_aa", 32'(sig_aa[1]), 32'hDB);
    drain(1, 1'b0);
    tick();

    // Asynchronous reset mid-run discards the partial signature
    do_start(1);
    in_valid[1] = 1'b1; aa[1] = 8'h00; bb[1] = 8'h00;
    tick();
    in_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_in_ready", 32'(in_ready[1]), 32'd0);
    chk("t4_rst_valid", 32'(sig_valid[1]), 32'd0);
    chk("t4_rst_sig_aa", 32'(sig_aa[1]), 32'd0);
    chk("t4_rst_sig_bb", 32'(sig_bb[1]), 32'd0);
    chk("t4_rst_busy", 32'(busy[1]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run(1, 2, 1'b0, 1'b1);
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("t4_sig_aa", 32'(sig_aa[1]), 32'hDB);
    chk("t4_sig_bb", 32'(sig_bb[1]), 32'hDB);
    drain(1, 1'b0);
    tick();

    // NSAMP=16: random data, random stalls and backpressure
    for (int r = 0; r < 4; r++) begin
      a0 = acc_cnt[2];
      run(2, 16, (r != 0), 1'b0);
      in_valid[2] = 1'b1;
      drain(2, 1'b1);
      tick();
      chk("t5_accepts", 32'(acc_cnt[2] - a0), 32'd16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
